// File: rtl/frame_config_writer.sv
// Configuration frame writer: decodes a header, collects NumberOfRows stream words into FrameData,
// then pulses one FrameStrobe line. Define FRAME_PARITY_EN to require an XOR trailer word per frame.
module frame_config_writer #(
    parameter int         FrameBitsPerRow = 32,
    parameter int         MaxFramesPerCol = 20,
    parameter int         NumberOfRows    = 16,
    parameter logic [7:0] ColumnId        = 8'd0
) (
    input  logic                                    CLK,
    input  logic                                    resetn,
    input  logic [31:0]                             in_data,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    output logic [FrameBitsPerRow*NumberOfRows-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0]              FrameStrobe,
    output logic                                    busy,
    output logic                                    frame_done,
    output logic                                    err_header,
    output logic [15:0]                             frame_count
);

    localparam int               ROW_W    = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NumberOfRows - 1);
    localparam logic [15:0]      MAGIC    = 16'hFAB0;
    localparam logic [8:0]       MAX_FR   = 9'(MaxFramesPerCol);

`ifdef FRAME_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DATA   = 3'd1,
        S_PARITY = 3'd2,
        S_SETUP  = 3'd3,
        S_STROBE = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DATA   = 3'd1,
        S_SETUP  = 3'd3,
        S_STROBE = 3'd4
    } state_t;
`endif

    state_t                                  r_state;
    state_t                                  w_next;
    logic                                    r_ready;
    logic                                    r_busy;
    logic                                    r_done;
    logic                                    r_err;
    logic [MaxFramesPerCol-1:0]              r_strobe;
    logic [15:0]                             r_count;
    logic [7:0]                              r_col;
    logic [7:0]                              r_frame;
    logic [ROW_W-1:0]                        r_row_cnt;
    logic [FrameBitsPerRow*NumberOfRows-1:0] r_frame_data;
`ifdef FRAME_PARITY_EN
    logic [31:0]                             r_xor;
    logic                                    w_parity_ok;
`endif

    logic                       w_accept;
    logic                       w_magic_ok;
    logic                       w_last_row;
    logic                       w_col_ok;
    logic                       w_frame_ok;
    logic                       w_fire;
    logic                       w_err;
    logic                       w_load_hdr;
    logic                       w_load_row;
    logic                       w_ready_next;
    logic [MaxFramesPerCol-1:0] w_sel;

    assign w_accept   = in_valid & r_ready;
    assign w_magic_ok = (in_data[31:16] == MAGIC);
    assign w_last_row = (r_row_cnt == LAST_ROW);
    assign w_col_ok   = (r_col == ColumnId);
    assign w_frame_ok = ({1'b0, r_frame} < MAX_FR);
`ifdef FRAME_PARITY_EN
    assign w_parity_ok = (in_data == r_xor);
`endif

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < MaxFramesPerCol; i++) begin
            w_sel[i] = (r_frame == 8'(i));
        end
    end

    always_comb begin
        w_next     = r_state;
        w_load_hdr = 1'b0;
        w_load_row = 1'b0;
        w_fire     = 1'b0;
        w_err      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_magic_ok) begin
                        w_load_hdr = 1'b1;
                        w_next     = S_DATA;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    w_load_row = 1'b1;
                    if (w_last_row) begin
`ifdef FRAME_PARITY_EN
                        w_next = S_PARITY;
`else
                        w_next = S_SETUP;
`endif
                    end
                end
            end
`ifdef FRAME_PARITY_EN
            S_PARITY: begin
                if (w_accept) begin
                    if (w_parity_ok) begin
                        w_next = S_SETUP;
                    end else begin
                        w_err  = 1'b1;
                        w_next = S_IDLE;
                    end
                end
            end
`endif
            // Strobe and range error are decided here so both leave flops during STROBE
            S_SETUP: begin
                w_next = S_STROBE;
                w_fire = w_col_ok & w_frame_ok;
                w_err  = ~w_frame_ok;
            end
            S_STROBE: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase

`ifdef FRAME_PARITY_EN
        w_ready_next = (w_next == S_IDLE) || (w_next == S_DATA) || (w_next == S_PARITY);
`else
        w_ready_next = (w_next == S_IDLE) || (w_next == S_DATA);
`endif
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_ready      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_strobe     <= '0;
            r_count      <= '0;
            r_col        <= '0;
            r_frame      <= '0;
            r_row_cnt    <= '0;
            r_frame_data <= '0;
        end else begin
            r_state  <= w_next;
            r_ready  <= w_ready_next;
            r_busy   <= (w_next != S_IDLE);
            r_done   <= w_fire;
            r_err    <= w_err;
            r_strobe <= w_fire ? w_sel : '0;
            if (w_fire) begin
                r_count <= r_count + 16'd1;
            end
            if (w_load_hdr) begin
                r_col     <= in_data[15:8];
                r_frame   <= in_data[7:0];
                r_row_cnt <= '0;
            end else if (w_load_row) begin
                r_row_cnt <= r_row_cnt + ROW_W'(1);
            end
            if (w_load_row) begin
                r_frame_data[r_row_cnt*FrameBitsPerRow +: FrameBitsPerRow] <= in_data[FrameBitsPerRow-1:0];
            end
        end
    end

`ifdef FRAME_PARITY_EN
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_xor <= '0;
        end else if (w_load_hdr) begin
            r_xor <= '0;
        end else if (w_load_row) begin
            r_xor <= r_xor ^ in_data;
        end
    end
`endif

    assign in_ready    = r_ready;
    assign busy        = r_busy;
    assign frame_done  = r_done;
    assign err_header  = r_err;
    assign FrameStrobe = r_strobe;
    assign frame_count = r_count;
    assign FrameData   = r_frame_data;

endmodule
